multitone_gen: RTL and testbench

MULTITONE_GEN -- requirements
Module: multitone_gen

---
 rtl/multitone_gen.sv | 158 +++++++++++++++
 tb/tb_multitone_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multitone_gen.sv
// Multi-channel square-wave tone generator with per-note duration timers and a
// registered speaker mixer (OR / XOR / round-robin / mute).
module multitone_gen #(
   parameter int FCLK  = 50000000,
   parameter int NCH   = 4,
   parameter int FW    = 32,
   parameter int RR_SH = 10
) (
   input  logic                                       clk,
   input  logic                                       reset_n,
   input  logic                                       wr,
   input  logic [((NCH > 1) ? $clog2(NCH) : 1) - 1:0] wr_ch,
   input  logic [FW-1:0]                              wr_freq,
   input  logic [15:0]                                wr_dur,
   input  logic [1:0]                                 mode,
   output logic [NCH-1:0]                             active,
   output logic [NCH-1:0]                             done,
   output logic [NCH-1:0]                             ch_out,
   output logic                                       spkr
);

   localparam int            CHW    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int            MS_DIV = (FCLK / 1000 < 1) ? 1 : FCLK / 1000;
   localparam logic [FW-1:0] F_HALF = FW'(FCLK / 2);
   localparam logic [FW+1:0] F_CLK  = (FW+2)'(FCLK);

   logic [FW-1:0]    freq_q [NCH];
   logic [FW-1:0]    freq_d [NCH];
   logic [15:0]      dur_q  [NCH];
   logic [15:0]      dur_d  [NCH];
   logic [FW:0]      acc_q  [NCH];
   logic [FW:0]      acc_d  [NCH];
   logic [FW+1:0]    acc_sum[NCH];
   logic [NCH-1:0]   sq_q, sq_d;
   logic [NCH-1:0]   active_q, active_d;
   logic [NCH-1:0]   done_q, done_d;
   logic [31:0]      ms_cnt_q, ms_cnt_d;
   logic             ms_tick;
   logic [RR_SH-1:0] slot_q, slot_d;
   logic [CHW-1:0]   sel_q, sel_d;
   logic [CHW-1:0]   rr_cand;
   logic             spkr_q, spkr_d;
   logic             wr_hit;
   logic [FW-1:0]    wr_freq_c;

   // Shared millisecond prescaler
   always_comb begin
      ms_tick  = (ms_cnt_q == 32'(MS_DIV - 1));
      ms_cnt_d = ms_tick ? '0 : ms_cnt_q + 32'd1;
   end

   always_comb begin
      wr_hit    = wr && (32'(wr_ch) < 32'(NCH));
      wr_freq_c = (wr_freq > F_HALF) ? F_HALF : wr_freq;
      for (int i = 0; i < NCH; i++) begin
         acc_sum[i] = (FW+2)'(acc_q[i]) + (FW+2)'({freq_q[i], 1'b0});
      end
   end

   // Priority per channel: write, then expiry, then normal tone/duration update.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         freq_d[i]   = freq_q[i];
         dur_d[i]    = dur_q[i];
         acc_d[i]    = acc_q[i];
         sq_d[i]     = sq_q[i];
         active_d[i] = active_q[i];
         done_d[i]   = 1'b0;
         if (wr_hit && (wr_ch == CHW'(i))) begin
            freq_d[i]   = wr_freq_c;
            dur_d[i]    = wr_dur;
            acc_d[i]    = '0;
            sq_d[i]     = 1'b0;
            active_d[i] = 1'b1;
         end else if (active_q[i] && ms_tick && (dur_q[i] == 16'd1)) begin
            dur_d[i]    = '0;
            acc_d[i]    = '0;
            sq_d[i]     = 1'b0;
            active_d[i] = 1'b0;
            done_d[i]   = 1'b1;
         end else begin
            if (active_q[i] && ms_tick && (dur_q[i] > 16'd1)) begin
               dur_d[i] = dur_q[i] - 16'd1;
            end
            if (!active_q[i] || (freq_q[i] == '0)) begin
               acc_d[i] = '0;
               sq_d[i]  = 1'b0;
            end else if (acc_sum[i] >= F_CLK) begin
               acc_d[i] = (FW+1)'(acc_sum[i] - F_CLK);
               sq_d[i]  = ~sq_q[i];
            end else begin
               acc_d[i] = (FW+1)'(acc_sum[i]);
            end
         end
      end
   end

   // Round-robin selector: at slot end, hop to the next active channel after sel.
   // Scanning downward lets the nearest candidate overwrite farther ones.
   always_comb begin
      slot_d  = slot_q + RR_SH'(1);
      sel_d   = sel_q;
      rr_cand = '0;
      for (int k = NCH; k >= 1; k--) begin
         rr_cand = CHW'((int'(sel_q) + k) % NCH);
         if ((&slot_q) && active_q[rr_cand]) begin
            sel_d = rr_cand;
         end
      end
   end

   always_comb begin
      case (mode)
         2'd0:    spkr_d = |sq_q;
         2'd1:    spkr_d = ^sq_q;
         2'd2:    spkr_d = sq_q[sel_q] & active_q[sel_q];
         default: spkr_d = 1'b0;
      endcase
   end

   // NOTE: the per-channel arrays are ordinary flops rather than a RAM, so they
   // are cleared by reset along with everything else.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            freq_q[i] <= '0;
            dur_q[i]  <= '0;
            acc_q[i]  <= '0;
         end
         sq_q     <= '0;
         active_q <= '0;
         done_q   <= '0;
         ms_cnt_q <= '0;
         slot_q   <= '0;
         sel_q    <= '0;
         spkr_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            freq_q[i] <= freq_d[i];
            dur_q[i]  <= dur_d[i];
            acc_q[i]  <= acc_d[i];
         end
         sq_q     <= sq_d;
         active_q <= active_d;
         done_q   <= done_d;
         ms_cnt_q <= ms_cnt_d;
         slot_q   <= slot_d;
         sel_q    <= sel_d;
         spkr_q   <= spkr_d;
      end
   end

   assign active = active_q;
   assign done   = done_q;
   assign ch_out = sq_q;
   assign spkr   = spkr_q;

endmodule

// File: tb/tb_multitone_gen.sv
// Directed bench for multitone_gen: FCLK=10000 so ms_tick lands every 10 clocks,
// RR_SH=3 so round-robin slots are 8 clocks. Edge k counts posedges after reset release.
module tb_multitone_gen;

   localparam int FCLK  = 10000;
   localparam int NCH   = 4;
   localparam int FW    = 32;
   localparam int RR_SH = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr;
   logic [1:0]  wr_ch;
   logic [31:0] wr_freq;
   logic [15:0] wr_dur;
   logic [1:0]  mode;
   logic [3:0]  active, done, ch_out;
   logic        spkr;
   logic [2:0]  active3, done3, ch_out3;
   logic        spkr3;

   int total = 0;
   int bad   = 0;
   int k     = 0;

   always #5 clk = ~clk;

   multitone_gen #(.FCLK(FCLK), .NCH(NCH), .FW(FW), .RR_SH(RR_SH)) u_dut (
      .clk(clk), .reset_n(reset_n), .wr(wr), .wr_ch(wr_ch), .wr_freq(wr_freq),
      .wr_dur(wr_dur), .mode(mode), .active(active), .done(done),
      .ch_out(ch_out), .spkr(spkr)
   );

   // Three-channel copy so that an out-of-range channel index is representable.
   multitone_gen #(.FCLK(FCLK), .NCH(3), .FW(FW), .RR_SH(RR_SH)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .wr(wr), .wr_ch(wr_ch), .wr_freq(wr_freq),
      .wr_dur(wr_dur), .mode(mode), .active(active3), .done(done3),
      .ch_out(ch_out3), .spkr(spkr3)
   );

   typedef struct {
      logic [1:0]  ch;
      logic [31:0] freq;
      logic [1:0]  mode;
      int          half;
      bit          spk_on;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (edge %0d): got %0h expected %0h", name, k, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      k++;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      wr      = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      k       = 0;
   endtask

   task automatic write(input logic [1:0] ch, input logic [31:0] f, input logic [15:0] d);
      wr      = 1'b1;
      wr_ch   = ch;
      wr_freq = f;
      wr_dur  = d;
      step();
      wr      = 1'b0;
   endtask

   initial begin
      int exp_v;
      reset_n = 1'b0;
      wr      = 1'b0;
      wr_ch   = '0;
      wr_freq = '0;
      wr_dur  = '0;
      mode    = 2'd0;

      vecs[0] = '{2'd0, 32'd1000, 2'd0, 5,  1'b1};
      vecs[1] = '{2'd1, 32'd2500, 2'd1, 2,  1'b1};
      vecs[2] = '{2'd2, 32'd9000, 2'd0, 1,  1'b1};
      vecs[3] = '{2'd3, 32'd500,  2'd0, 10, 1'b1};
      vecs[4] = '{2'd1, 32'd0,    2'd0, 0,  1'b1};
      vecs[5] = '{2'd0, 32'd1000, 2'd3, 5,  1'b0};
      vecs[6] = '{2'd3, 32'd5001, 2'd1, 1,  1'b1};

      // Reset state, with a write held during reset that must be discarded
      wr = 1'b1; wr_ch = 2'd0; wr_freq = 32'd1000; wr_dur = 16'd0;
      repeat (3) step();
      wr = 1'b0; reset_n = 1'b1; k = 0;
      check("reset_active", active, 0);
      check("reset_done",   done,   0);
      check("reset_chout",  ch_out, 0);
      check("reset_spkr",   spkr,   0);
      repeat (12) step();
      check("rstwr_active", active, 0);
      check("rstwr_chout",  ch_out, 0);

      // Table: single-channel tone periods, clamp, silent channel, mix modes
      for (int v = 0; v < 7; v++) begin
         do_reset();
         mode = vecs[v].mode;
         write(vecs[v].ch, vecs[v].freq, 16'd0);
         check($sformatf("tab%0d_active", v), active, 4'b0001 << vecs[v].ch);
         for (int j = 1; j <= 24; j++) begin
            step();
            exp_v = (vecs[v].half == 0) ? 0 : (j / vecs[v].half) % 2;
            check($sformatf("tab%0d_chout_j%0d", v, j), ch_out[vecs[v].ch], exp_v);
            exp_v = (vecs[v].half == 0 || !vecs[v].spk_on) ? 0 : ((j - 1) / vecs[v].half) % 2;
            check($sformatf("tab%0d_spkr_j%0d", v, j), spkr, exp_v);
            check($sformatf("tab%0d_done_j%0d", v, j), done, 0);
         end
      end

      // Duration 3 ms on ch1: written at edge 1, ticks at 10/20/30
      do_reset();
      write(2'd1, 32'd500, 16'd3);
      for (int n = 2; n <= 40; n++) begin
         step();
         check("dur_done",   done[1],   (k == 30) ? 1 : 0);
         check("dur_active", active[1], (k < 30) ? 1 : 0);
         check("dur_chout",  ch_out[1], (k < 30) ? ((k - 1) / 10) % 2 : 0);
      end

      // Two channels expiring on the same tick
      do_reset();
      write(2'd0, 32'd1000, 16'd2);
      write(2'd2, 32'd1000, 16'd2);
      for (int n = 3; n <= 25; n++) begin
         step();
         check("multi_done", done, (k == 20) ? 4'b0101 : 4'b0000);
      end

      // In-phase pair under XOR, then OR
      do_reset();
      mode = 2'd1;
      write(2'd0, 32'd1000, 16'd0);
      while (k < 10) step();
      write(2'd2, 32'd1000, 16'd0);
      for (int n = 12; n <= 40; n++) begin
         step();
         check("xor_spkr",  spkr,      0);
         check("xor_ch0",   ch_out[0], ((k - 1) / 5) % 2);
         check("xor_ch2",   ch_out[2], ((k - 11) / 5) % 2);
      end
      mode = 2'd0;
      for (int n = 41; n <= 55; n++) begin
         step();
         check("or_spkr", spkr, ((k - 2) / 5) % 2);
         check("or_done", done, 0);
      end

      // Round-robin between ch0 (toggling each clock) and ch3 (active, silent)
      do_reset();
      mode = 2'd2;
      write(2'd0, 32'd5000, 16'd0);
      write(2'd3, 32'd0,    16'd0);
      for (int n = 3; n <= 40; n++) begin
         step();
         exp_v = ((((k - 1) / 8) % 2) == 0 && ((k - 1) % 2) == 0 && (k - 1) >= 2) ? 1 : 0;
         check("rr_spkr", spkr, exp_v);
      end
      mode = 2'd3;
      for (int n = 41; n <= 48; n++) begin
         step();
         check("mute_spkr", spkr, 0);
      end

      // Rewrite on the exact expiry edge: write wins
      do_reset();
      mode = 2'd0;
      write(2'd1, 32'd500, 16'd2);
      while (k < 19) begin
         step();
         check("rew_pre_done", done, 0);
      end
      write(2'd1, 32'd5000, 16'd0);
      check("rew_done",   done[1],   0);
      check("rew_active", active[1], 1);
      for (int n = 21; n <= 40; n++) begin
         step();
         check("rew_post_done",   done,      0);
         check("rew_post_active", active[1], 1);
         check("rew_post_chout",  ch_out[1], (k - 20) % 2);
      end

      // Mid-note reset silences everything on the same edge
      check("mid_pre_spkr", spkr, 1);
      reset_n = 1'b0;
      step();
      check("mid_active", active, 0);
      check("mid_done",   done,   0);
      check("mid_chout",  ch_out, 0);
      check("mid_spkr",   spkr,   0);
      reset_n = 1'b1;

      // Reset landing on an expiry edge produces no done pulse
      do_reset();
      write(2'd2, 32'd500, 16'd1);
      while (k < 9) step();
      reset_n = 1'b0;
      step();
      check("rstexp_done", done, 0);
      reset_n = 1'b1;
      k = 0;
      for (int n = 1; n <= 12; n++) begin
         step();
         check("rstexp_after_done",   done,   0);
         check("rstexp_after_active", active, 0);
      end

      // Out-of-range channel index on the three-channel instance
      do_reset();
      write(2'd3, 32'd1000, 16'd0);
      check("oor_ref_active", active[3], 1);
      check("oor_active3",    active3,   0);
      repeat (6) step();
      check("oor_chout3",     ch_out3,   0);
      write(2'd2, 32'd1000, 16'd0);
      check("inr_active3",    active3,   3'b100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
